// File: rtl/pc_pkg.sv
// Shared definitions for the PC fetch unit.
// Holds the next-PC select encodings, reset constants and the fetch FSM states.
package pc_pkg;

  localparam logic [1:0] PC_PLUS4     = 2'b00;
  localparam logic [1:0] PC_IMM       = 2'b01;
  localparam logic [1:0] PC_JALR      = 2'b10;
  localparam logic [1:0] PC_PLUS4_ALT = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    HALT  = 2'b00,
    FETCH = 2'b01,
    ISSUE = 2'b10,
    TRAP  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection with misalignment detection.
// All sums wrap at XLEN bits; JALR targets have bit 0 cleared.
module next_pc_calc
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [1:0]      PCsrc,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] jr_sum;

  assign seq_pc = pc + XLEN'(4);
  assign br_pc  = pc + imm;
  assign jr_sum = rs1_data + imm;

  always_comb begin
    next_pc = seq_pc;
    unique case (PCsrc)
      PC_IMM:  next_pc = br_pc;
      PC_JALR: next_pc = {jr_sum[XLEN-1:1], 1'b0};
      default: next_pc = seq_pc;
    endcase
  end

  // Word alignment only: bit 0 is either cleared or allowed through.
  assign misaligned = next_pc[1];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer.
// Fetches one word, issues it, and advances the PC on acknowledge.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [1:0]      PCsrc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            instr_ack,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic            misalign_err
);

  fetch_state_e state;
  fetch_state_e state_next;

  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            err_q;

  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            fetch_done;
  logic            ack_go;

  next_pc_calc #(
    .XLEN(XLEN)
  ) u_next_pc (
    .pc        (pc_q),
    .imm       (imm),
    .rs1_data  (rs1_data),
    .PCsrc     (PCsrc),
    .next_pc   (next_pc),
    .misaligned(misaligned)
  );

  assign fetch_done = (state == FETCH) && imem_ready;
  assign ack_go     = (state == ISSUE) && instr_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HALT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      HALT: begin
        if (run) state_next = FETCH;
      end
      // run is not consulted here so an open request always completes
      FETCH: begin
        if (imem_ready) state_next = ISSUE;
      end
      ISSUE: begin
        if (instr_ack) begin
          if (misaligned)
            state_next = TRAP;
          else if (run)
            state_next = FETCH;
          else
            state_next = HALT;
        end
      end
      TRAP: begin
        state_next = TRAP;
      end
      default: state_next = HALT;
    endcase
  end

  // Decoded straight from state so reset drops the request at once.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      FETCH:   imem_req    = 1'b1;
      ISSUE:   instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      err_q   <= 1'b0;
    end else begin
      if (fetch_done)
        instr_q <= imem_rdata;
      if (ack_go) begin
        if (misaligned)
          err_q <= 1'b1;
        else
          pc_q <= next_pc;
      end
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_q + XLEN'(4);
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign misalign_err = err_q;

endmodule
